// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: pops the PS/2 receiver FIFO one byte at a time, decodes
// F0/E0 prefixes and modifier state, and queues 16-bit key events in a FWFT
// FIFO for the CPU.
// Optional feature macro: KBD_TYPEMATIC_EN. When defined, typematic repeats
// are queued with bit [10] set. When undefined, repeats are dropped silently.
module kbd_event_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_ready,
  input  logic [7:0]                  ps2_byte,
  input  logic                        ps2_overflow,
  output logic                        ps2_nextdata_n,
  input  logic                        evt_rd,
  output logic                        evt_valid,
  output logic [15:0]                 evt_data,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        ovf_seen,
  input  logic                        clr_status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t     state;
  logic       brk, ext;
  logic       shift_l, shift_r, ctrl, caps;
  logic       lm_vld;
  logic [8:0] lm;

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic capture, is_code, make, is_rep, rep_bit, push, pop, full, wr_en, drop;
  logic shift_l_n, shift_r_n, ctrl_n, caps_n;
  logic [15:0] evt_word;

  assign capture = (state == IDLE) && ps2_ready;
  assign is_code = capture && (ps2_byte != 8'hF0) && (ps2_byte != 8'hE0);
  assign make    = !brk;
  assign is_rep  = make && lm_vld && (lm == {ext, ps2_byte});

  // Next modifier state; the event reports the state after this byte.
  always_comb begin
    shift_l_n = shift_l;
    shift_r_n = shift_r;
    ctrl_n    = ctrl;
    caps_n    = caps;
    if (is_code) begin
      if (!ext && ps2_byte == 8'h12) shift_l_n = make;
      if (!ext && ps2_byte == 8'h59) shift_r_n = make;
      if (ps2_byte == 8'h14)         ctrl_n    = make;
      if (!ext && ps2_byte == 8'h58 && make && !is_rep) caps_n = !caps;
    end
  end

`ifdef KBD_TYPEMATIC_EN
  assign rep_bit = is_rep;
  assign push    = is_code;
`else
  assign rep_bit = 1'b0;
  assign push    = is_code && !is_rep;
`endif

  assign evt_word = {make, ext, ctrl_n, shift_l_n | shift_r_n, caps_n, rep_bit,
                     2'b00, ps2_byte};

  assign evt_valid = (evt_count != '0);
  assign full      = (evt_count == FULL_CNT);
  assign pop       = evt_rd && evt_valid;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign evt_data  = evt_valid ? mem[rd_ptr] : 16'h0000;

  // Pop handshake FSM plus prefix, modifier and repeat-tracking state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ps2_nextdata_n <= 1'b1;
      brk            <= 1'b0;
      ext            <= 1'b0;
      shift_l        <= 1'b0;
      shift_r        <= 1'b0;
      ctrl           <= 1'b0;
      caps           <= 1'b0;
      lm_vld         <= 1'b0;
      lm             <= '0;
    end else begin
      case (state)
        IDLE: if (ps2_ready) begin
          state          <= POP;
          ps2_nextdata_n <= 1'b0;
          if (ps2_byte == 8'hF0)      brk <= 1'b1;
          else if (ps2_byte == 8'hE0) ext <= 1'b1;
          else begin
            brk     <= 1'b0;
            ext     <= 1'b0;
            shift_l <= shift_l_n;
            shift_r <= shift_r_n;
            ctrl    <= ctrl_n;
            caps    <= caps_n;
            if (make && !is_rep) begin
              lm_vld <= 1'b1;
              lm     <= {ext, ps2_byte};
            end else if (!make && lm_vld && lm == {ext, ps2_byte}) begin
              lm_vld <= 1'b0;
            end
          end
        end
        POP: begin
          state          <= GAP;
          ps2_nextdata_n <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Event FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= evt_word;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
    end
  end

  // Status: clear first, then apply any same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      ovf_seen <= 1'b0;
    end else begin
      ovf_seen <= (ovf_seen && !clr_status) || ps2_overflow;
      if (clr_status)                   drop_cnt <= drop ? CNT_W'(1) : '0;
      else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Directed bench for kbd_event_ctrl: drives a model PS/2 receiver, queues the
// expected events in a scoreboard and compares them as the FIFO is drained.
module tb_kbd_event_ctrl;

  logic        clk = 1'b0;
  logic        rst, ps2_ready, ps2_overflow, evt_rd, clr_status;
  logic [7:0]  ps2_byte;
  logic        ps2_nextdata_n, evt_valid, ovf_seen;
  logic [15:0] evt_data;
  logic [3:0]  evt_count;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic vld_at_cap;
  logic [15:0] sb[$];

  kbd_event_ctrl #(.FIFO_DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_byte(ps2_byte),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
    .evt_rd(evt_rd), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_count(evt_count), .drop_cnt(drop_cnt), .ovf_seen(ovf_seen),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ps2_nextdata_n === 1'b0) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte while the DUT is idle, hold it until popped, then let
  // the GAP cycle pass so the next call starts in IDLE again.
  task automatic feed(input logic [7:0] b, input logic rd = 1'b0, input logic clr = 1'b0);
    logic got;
    got = 1'b0;
    @(negedge clk);
    ps2_byte = b; ps2_ready = 1'b1; evt_rd = rd; clr_status = clr;
    @(posedge clk); #1;
    vld_at_cap = evt_valid;
    evt_rd = 1'b0; clr_status = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ps2_nextdata_n === 1'b0) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!got) check("pop_timeout", 0, 1);
    @(posedge clk); #1;
    ps2_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    logic [15:0] e;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!evt_valid) break;
      if (sb.size() == 0) check({tag, "_extra"}, evt_data, 16'hxxxx);
      else begin
        e = sb.pop_front();
        check(tag, evt_data, e);
      end
      evt_rd = 1'b1;
      @(posedge clk); #1;
      evt_rd = 1'b0;
    end
    check({tag, "_left"}, sb.size(), 0);
    @(negedge clk);
    check({tag, "_empty"}, evt_valid, 0);
  endtask

  initial begin
    logic [7:0] codes [10];
    int p0;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    rst = 1'b1; ps2_ready = 1'b0; ps2_byte = 8'h00; ps2_overflow = 1'b0;
    evt_rd = 1'b0; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_nextdata_n", ps2_nextdata_n, 1);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_count", evt_count, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_ovf_seen", ovf_seen, 0);

    // Basic make/break with handshake pulse count and push latency.
    p0 = pulses;
    check("t1_pre_valid", evt_valid, 0);
    feed(8'h1C); sb.push_back(16'h801C);
    check("t1_valid_latency", vld_at_cap, 1);
    feed(8'hF0); feed(8'h1C); sb.push_back(16'h001C);
    check("t1_pulses", pulses - p0, 3);
    check("t1_count", evt_count, 2);
    drain("t1");

    // Shift modifier.
    feed(8'h12); feed(8'h1C); feed(8'hF0); feed(8'h1C); feed(8'hF0); feed(8'h12);
    sb.push_back(16'h9012); sb.push_back(16'h901C);
    sb.push_back(16'h101C); sb.push_back(16'h0012);
    drain("t2");

    // CapsLock toggle and toggle back.
    feed(8'h58); feed(8'hF0); feed(8'h58); feed(8'h1C);
    feed(8'h58); feed(8'hF0); feed(8'h58); feed(8'hF0); feed(8'h1C);
    sb.push_back(16'h8858); sb.push_back(16'h0858); sb.push_back(16'h881C);
    sb.push_back(16'h8058); sb.push_back(16'h0058); sb.push_back(16'h001C);
    drain("t3");

    // Extended prefix, cleared after use.
    feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75); feed(8'h75);
    feed(8'hF0); feed(8'h75);
    sb.push_back(16'hC075); sb.push_back(16'h4075);
    sb.push_back(16'h8075); sb.push_back(16'h0075);
    drain("t4");

    // Typematic repeats.
    feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
    sb.push_back(16'h801C);
`ifdef KBD_TYPEMATIC_EN
    sb.push_back(16'h841C); sb.push_back(16'h841C);
`endif
    sb.push_back(16'h001C);
    drain("t5");

    // Fill past capacity, then full-with-pop, clear interactions.
    for (int i = 0; i < 10; i++) begin
      feed(codes[i]);
      if (i < 8) sb.push_back({8'h80, codes[i]});
    end
    check("t6_count_full", evt_count, 8);
    check("t6_drop", drop_cnt, 2);
    @(negedge clk);
    check("t6_head", evt_data, sb.pop_front());
    feed(8'h1B, 1'b1); sb.push_back(16'h801B);
    check("t6_count_push_pop", evt_count, 8);
    check("t6_drop_unchanged", drop_cnt, 2);
    feed(8'h1A, 1'b0, 1'b1);
    check("t6_clr_and_drop", drop_cnt, 1);
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    check("t6_clr", drop_cnt, 0);
    ps2_overflow = 1'b1; clr_status = 1'b1;
    @(negedge clk); ps2_overflow = 1'b0; clr_status = 1'b0;
    check("t6_ovf_clr_set", ovf_seen, 1);
    @(negedge clk); check("t6_ovf_sticky", ovf_seen, 1);
    clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    check("t6_ovf_clr", ovf_seen, 0);
    drain("t6");
    check("t6_count_end", evt_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
